// File: rtl/pkt_ring_buffer.sv
// pkt_ring_buffer: packet-aware ring buffer with speculative writes, atomic commit and rollback
module pkt_ring_buffer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int AFULL_THRESH = 2**ADDR_W-64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_abort,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              emptied,
  output logic              empty_next,
  output logic              filled,
  output logic              full_next,
  output logic              almost_full,
  output logic [ADDR_W:0]   fill_counter,
  output logic [ADDR_W:0]   pkt_count,
  output logic [15:0]       drop_count
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_P = (ADDR_W+1)'(AFULL_THRESH);
  typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;
  state_t state, state_nxt;
  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;
  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W:0] wr_nxt, commit_nxt, rd_nxt, tot_nxt, com_nxt, pkt_nxt;
  logic room, we, commit, drop, rd_acc;
  // room is judged on occupancy at the start of the cycle; a same-cycle read does not help
  assign room = (wr_ptr - rd_ptr) != DEPTH_P;
  assign rd_acc = rd_en && (commit_ptr != rd_ptr);
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_nxt = rd_ptr + (rd_acc ? ONE : '0);
  assign tot_nxt = wr_nxt - rd_nxt;
  assign com_nxt = commit_nxt - rd_nxt;
  assign pkt_nxt = pkt_count + (commit ? ONE : '0) - ((rd_acc && rd_word[DATA_W]) ? ONE : '0);
  // writer FSM: decide write, commit, rollback and drop for this cycle
  always_comb begin
    state_nxt = state;
    wr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    we = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    if (state != IDLE && wr_abort) begin
      wr_nxt = commit_ptr;
      drop = state == ACCUM;
      state_nxt = IDLE;
    end else if (wr_en && state == DROP) begin
      state_nxt = wr_last ? IDLE : DROP;
    end else if (wr_en && room) begin
      we = 1'b1;
      wr_nxt = wr_ptr + ONE;
      commit = wr_last;
      commit_nxt = wr_last ? wr_ptr + ONE : commit_ptr;
      state_nxt = wr_last ? IDLE : ACCUM;
    end else if (wr_en) begin
      wr_nxt = commit_ptr;
      drop = 1'b1;
      state_nxt = wr_last ? IDLE : DROP;
    end
  end
  // state and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_nxt;
      commit_ptr <= commit_nxt;
      rd_ptr <= rd_nxt;
    end
  end
  // storage; the extra top bit carries the packet-end marker
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
  end
  // registered read port, one cycle after an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_last <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      rd_data <= rd_acc ? rd_word[DATA_W-1:0] : rd_data;
      rd_last <= rd_acc && rd_word[DATA_W];
    end
  end
  // status flags and counters registered from next-state pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_counter <= '0;
      emptied <= 1'b1;
      empty_next <= 1'b0;
      filled <= 1'b0;
      full_next <= 1'b0;
      almost_full <= 1'b0;
      pkt_count <= '0;
      drop_count <= '0;
    end else begin
      fill_counter <= com_nxt;
      emptied <= com_nxt == '0;
      empty_next <= com_nxt == ONE;
      filled <= tot_nxt == DEPTH_P;
      full_next <= tot_nxt == DEPTH_P - ONE;
      almost_full <= tot_nxt >= AFULL_P;
      pkt_count <= pkt_nxt;
      drop_count <= drop_count + ((drop && drop_count != 16'hFFFF) ? 16'd1 : 16'd0);
    end
  end
endmodule

// File: tb/tb_pkt_ring_buffer.sv
// tb_pkt_ring_buffer: scoreboard bench for the packet ring buffer at DEPTH=16
module tb_pkt_ring_buffer;
  localparam int DW = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, wr_last = 1'b0, wr_abort = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid, rd_last, emptied, empty_next, filled, full_next, almost_full;
  logic [DW-1:0] rd_data;
  logic [AW:0] fill_counter, pkt_count;
  logic [15:0] drop_count;
  logic [DW:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;

  pkt_ring_buffer #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_abort(wr_abort), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .emptied(emptied), .empty_next(empty_next), .filled(filled),
    .full_next(full_next), .almost_full(almost_full), .fill_counter(fill_counter),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic l);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = l;
    cyc();
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic do_reset();
    {wr_en, wr_last, wr_abort, rd_en} = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string nm);
    int b = 0;
    logic [DW:0] e;
    rd_en = 1'b1;
    while (sb.size() > 0 && b < 100) begin
      cyc();
      b++;
      if (rd_valid) begin
        e = sb.pop_front();
        n_chk++;
        if ({rd_last, rd_data} !== e) begin
          n_fail++;
          $display("FAIL %s_data: got %0h expected %0h", nm, {rd_last, rd_data}, e);
        end
      end
    end
    rd_en = 1'b0;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d words outstanding expected 0", nm, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({rd_valid, rd_last, emptied, empty_next, filled, full_next, almost_full} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0010000",
               {rd_valid, rd_last, emptied, empty_next, filled, full_next, almost_full});
    end
    n_chk++;
    if ({fill_counter, pkt_count, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0h/%0h/%0h expected 0/0/0", fill_counter, pkt_count, drop_count);
    end
  endtask

  task automatic test_commit();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(DW'(i), i == 4);
      sb.push_back({i == 4, DW'(i)});
      if (i < 4) begin
        n_chk++;
        if (fill_counter !== 0) begin
          n_fail++;
          $display("FAIL commit_spec_fill: got %0d expected 0", fill_counter);
        end
      end
    end
    n_chk++;
    if ({fill_counter, pkt_count, emptied} !== {5'd5, 5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL commit_fill: got %0d/%0d/%b expected 5/1/0", fill_counter, pkt_count, emptied);
    end
    drain("commit");
    n_chk++;
    if ({emptied, pkt_count, fill_counter} !== {1'b1, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL commit_after: got %b/%0d/%0d expected 1/0/0", emptied, pkt_count, fill_counter);
    end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    n_chk++;
    if ({rd_valid, emptied, fill_counter} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL empty_read: got %b/%b/%0d expected 0/1/0", rd_valid, emptied, fill_counter);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 3; i++) wr(DW'(16'h10 + i), 1'b0);
    wr_abort = 1'b1;
    wr(16'h55, 1'b1);
    wr_abort = 1'b0;
    n_chk++;
    if ({fill_counter, drop_count, emptied} !== {5'd0, 16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_state: got %0d/%0d/%b expected 0/1/1", fill_counter, drop_count, emptied);
    end
    wr(16'hA0, 1'b0);
    wr(16'hA1, 1'b1);
    sb.push_back({1'b0, 16'hA0});
    sb.push_back({1'b1, 16'hA1});
    n_chk++;
    if ({fill_counter, empty_next} !== {5'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_refill: got %0d/%b expected 2/0", fill_counter, empty_next);
    end
    drain("abort");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr(DW'(16'h100 + i), i == 11);
      sb.push_back({i == 11, DW'(16'h100 + i)});
    end
    n_chk++;
    if ({fill_counter, almost_full, filled} !== {5'd12, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_first: got %0d/%b/%b expected 12/1/0", fill_counter, almost_full, filled);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        n_chk++;
        if ({filled, full_next} !== 2'b10) begin
          n_fail++;
          $display("FAIL ovf_filled: got %b expected 10", {filled, full_next});
        end
      end
      wr(DW'(16'h200 + i), i == 5);
      if (i == 2) begin
        n_chk++;
        if ({filled, full_next} !== 2'b01) begin
          n_fail++;
          $display("FAIL ovf_full_next: got %b expected 01", {filled, full_next});
        end
      end
      if (i == 4) begin
        n_chk++;
        if ({drop_count, filled} !== {16'd1, 1'b0}) begin
          n_fail++;
          $display("FAIL ovf_drop: got %0d/%b expected 1/0", drop_count, filled);
        end
      end
    end
    n_chk++;
    if ({drop_count, fill_counter, pkt_count} !== {16'd1, 5'd12, 5'd1}) begin
      n_fail++;
      $display("FAIL ovf_after: got %0d/%0d/%0d expected 1/12/1", drop_count, fill_counter, pkt_count);
    end
    drain("ovf");
    n_chk++;
    if ({emptied, pkt_count} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL ovf_empty: got %b/%0d expected 1/0", emptied, pkt_count);
    end
  endtask

  task automatic test_long_drop();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr(DW'(16'h300 + i), i == 19);
      if (i == 15) begin
        n_chk++;
        if ({filled, drop_count} !== {1'b1, 16'd0}) begin
          n_fail++;
          $display("FAIL long_full: got %b/%0d expected 1/0", filled, drop_count);
        end
      end
      if (i == 16) begin
        n_chk++;
        if (drop_count !== 16'd1) begin
          n_fail++;
          $display("FAIL long_drop_at17: got %0d expected 1", drop_count);
        end
      end
    end
    n_chk++;
    if ({drop_count, emptied, fill_counter, pkt_count, filled} !== {16'd1, 1'b1, 5'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL long_after: got %0d/%b/%0d/%0d/%b expected 1/1/0/0/0",
               drop_count, emptied, fill_counter, pkt_count, filled);
    end
    wr_abort = 1'b1;
    wr(16'h3FF, 1'b1);
    wr_abort = 1'b0;
    sb.push_back({1'b1, 16'h3FF});
    n_chk++;
    if ({fill_counter, empty_next, drop_count} !== {5'd1, 1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL long_idle: got %0d/%b/%0d expected 1/1/1", fill_counter, empty_next, drop_count);
    end
    drain("long");
  endtask

  task automatic test_back_to_back();
    logic [DW:0] e;
    do_reset();
    rd_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      for (int w = 0; w < 7; w++) begin
        wr_en = 1'b1;
        wr_data = DW'(p * 7 + w);
        wr_last = (w == 6);
        sb.push_back({wr_last, wr_data});
        cyc();
        if (rd_valid) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL wrap_extra: got word %0h expected none", rd_data);
          end else begin
            e = sb.pop_front();
            if ({rd_last, rd_data} !== e) begin
              n_fail++;
              $display("FAIL wrap_data: got %0h expected %0h", {rd_last, rd_data}, e);
            end
          end
        end
        n_chk++;
        if (pkt_count > 2) begin
          n_fail++;
          $display("FAIL wrap_pkts: got %0d expected <= 2", pkt_count);
        end
      end
    end
    wr_en = 1'b0;
    wr_last = 1'b0;
    drain("wrap");
    n_chk++;
    if ({drop_count, pkt_count, emptied} !== {16'd0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_end: got %0d/%0d/%b expected 0/0/1", drop_count, pkt_count, emptied);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) wr(DW'(16'h400 + i), i == 8);
    for (int i = 0; i < 3; i++) wr(DW'(16'h480 + i), 1'b0);
    rd_en = 1'b1;
    wr(16'h483, 1'b0);
    rd_en = 1'b0;
    n_chk++;
    if ({rd_valid, fill_counter} !== {1'b1, 5'd8}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %b/%0d expected 1/8", rd_valid, fill_counter);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({rd_valid, emptied} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 01", {rd_valid, emptied});
    end
    cyc();
    n_chk++;
    if ({emptied, fill_counter, rd_valid, pkt_count} !== {1'b1, 5'd0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL rstmid_state: got %b/%0d/%b/%0d expected 1/0/0/0", emptied, fill_counter, rd_valid, pkt_count);
    end
    rst = 1'b0;
    sb.delete();
    wr_abort = 1'b1;
    wr(16'h4AA, 1'b1);
    wr_abort = 1'b0;
    sb.push_back({1'b1, 16'h4AA});
    n_chk++;
    if ({fill_counter, drop_count} !== {5'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL rstmid_idle: got %0d/%0d expected 1/0", fill_counter, drop_count);
    end
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_commit();
    test_abort();
    test_overflow();
    test_long_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
